// File: rtl/pmem_pkg.sv
// ---------------------------------------------------------------------------
// pmem_pkg
//
// Shared definitions for the physical-memory burst responder:
//   - pmem_state_t : responder FSM states
//   - BEAT_BITS    : width of one burst beat on the memory bus
//   - LAT_CNT_BITS : width of the access-latency counter (LATENCY <= 255)
//   - req_conflict : true when both request lines are raised together
// ---------------------------------------------------------------------------
package pmem_pkg;

  localparam int BEAT_BITS    = 64;
  localparam int LAT_CNT_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } pmem_state_t;

  // Read and write together never describe a legal request.
  function automatic logic req_conflict(input logic rd, input logic wr);
    return rd & wr;
  endfunction

endpackage

// File: rtl/pmem_burst_responder_if.sv
// ---------------------------------------------------------------------------
// pmem_burst_responder_if
//
// Burst bus between the cacheline adaptor (master) and the physical-memory
// responder (slave).
//   pmem_read     master->slave  read request, held until the last beat
//   pmem_write    master->slave  write request, held until the last beat
//   pmem_address  master->slave  byte address of the line
//   pmem_wdata    master->slave  write beat
//   pmem_resp     slave->master  one-cycle strobe per beat
//   pmem_rdata    slave->master  read beat, zero when pmem_resp is low
//   pmem_err      slave->master  sticky protocol-violation flag
// ---------------------------------------------------------------------------
interface pmem_burst_responder_if;
  import pmem_pkg::*;

  logic                 pmem_read;
  logic                 pmem_write;
  logic [31:0]          pmem_address;
  logic [BEAT_BITS-1:0] pmem_wdata;
  logic                 pmem_resp;
  logic [BEAT_BITS-1:0] pmem_rdata;
  logic                 pmem_err;

  modport master (
    output pmem_read,
    output pmem_write,
    output pmem_address,
    output pmem_wdata,
    input  pmem_resp,
    input  pmem_rdata,
    input  pmem_err
  );

  modport slave (
    input  pmem_read,
    input  pmem_write,
    input  pmem_address,
    input  pmem_wdata,
    output pmem_resp,
    output pmem_rdata,
    output pmem_err
  );

endinterface

// File: rtl/pmem_line_store.sv
// ---------------------------------------------------------------------------
// pmem_line_store
//
// Single-port word array backing the responder. Writes happen on the rising
// clock edge; reads are asynchronous so the responder can register the
// selected word straight into its output beat.
//   clk    in   clock
//   we     in   write enable for addr
//   addr   in   word address {line, beat}
//   wdata  in   word to store
//   rdata  out  word currently stored at addr
// Contents are never cleared by reset.
// ---------------------------------------------------------------------------
module pmem_line_store
  import pmem_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [BEAT_BITS-1:0] wdata,
  output logic [BEAT_BITS-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [BEAT_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/pmem_burst_responder.sv
// ---------------------------------------------------------------------------
// pmem_burst_responder
//
// Physical-memory endpoint for the 64-bit line-burst bus. Accepts one read or
// write of a whole line, waits LATENCY cycles, then moves the line as BEATS
// consecutive beats with pmem_resp high for each, followed by one idle DONE
// cycle in which the request lines are ignored.
//   clk      in   clock
//   reset_n  in   synchronous active-low reset
//   bus      slave side of pmem_burst_responder_if
// Parameters:
//   s_offset  log2 of line size in bytes (line = 2**s_offset bytes)
//   s_lines   log2 of the number of stored lines
//   LATENCY   cycles from acceptance to the first beat, 1..255
// ---------------------------------------------------------------------------
module pmem_burst_responder
  import pmem_pkg::*;
#(
  parameter int s_offset = 5,
  parameter int s_lines  = 10,
  parameter int LATENCY  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pmem_burst_responder_if.slave  bus
);

  localparam int BEATS   = (2 ** s_offset) / 8;
  localparam int BEAT_W  = $clog2(BEATS);
  localparam int LINE_LO = s_offset;
  localparam int LINE_HI = s_offset + s_lines - 1;
  localparam int WORD_W  = s_lines + BEAT_W;

  localparam logic [LAT_CNT_BITS-1:0] LAT_LOAD  = LAT_CNT_BITS'(LATENCY - 1);
  localparam logic [LAT_CNT_BITS-1:0] LAT_ONE   = LAT_CNT_BITS'(1);
  localparam logic [BEAT_W-1:0]       LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0]       BEAT_ONE  = BEAT_W'(1);

  // State and its next values
  pmem_state_t               state_reg, state_next;
  logic                      op_write_reg, op_write_next;
  logic [s_lines-1:0]        line_reg, line_next;
  logic [LAT_CNT_BITS-1:0]   lat_cnt_reg, lat_cnt_next;
  logic [BEAT_W-1:0]         beat_reg, beat_next;
  logic                      err_reg, err_next;
  logic                      resp_reg, resp_next;
  logic [BEAT_BITS-1:0]      rdata_reg, rdata_next;

  // Request decode
  logic [s_lines-1:0]        addr_line;
  logic                      in_txn;
  logic                      req_active;
  logic                      req_other;
  logic                      proto_violation;

  // Storage port
  logic                      write_beat;
  logic                      mem_we;
  logic [WORD_W-1:0]         mem_addr;
  logic [BEAT_BITS-1:0]      mem_rdata;

  // Offset bits and bits above the capacity do not select anything; lines
  // alias modulo the capacity and every burst starts at beat 0.
  logic [31-LINE_HI+LINE_LO-1:0] unused_addr_bits;
  assign unused_addr_bits = {bus.pmem_address[31:LINE_HI+1],
                             bus.pmem_address[LINE_LO-1:0]};

  assign addr_line = bus.pmem_address[LINE_HI:LINE_LO];

  // ------------------------------------------------------------------------
  // Protocol checker: while a transaction is outstanding the initiator must
  // hold the same line and only the request it started with. Violations are
  // flagged but the transaction carries on from the latched op and line.
  // ------------------------------------------------------------------------
  assign in_txn          = (state_reg == WAIT) || (state_reg == BURST);
  assign req_active      = op_write_reg ? bus.pmem_write : bus.pmem_read;
  assign req_other       = op_write_reg ? bus.pmem_read  : bus.pmem_write;
  assign proto_violation = in_txn &&
                           ((addr_line != line_reg) || !req_active || req_other);

  // ------------------------------------------------------------------------
  // FSM next-state and datapath updates
  // ------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    op_write_next = op_write_reg;
    line_next     = line_reg;
    lat_cnt_next  = lat_cnt_reg;
    beat_next     = beat_reg;
    err_next      = err_reg;

    case (state_reg)
      IDLE: begin
        beat_next = '0;
        if (req_conflict(bus.pmem_read, bus.pmem_write)) begin
          err_next = 1'b1;
        end else if (bus.pmem_read || bus.pmem_write) begin
          op_write_next = bus.pmem_write;
          line_next     = addr_line;
          lat_cnt_next  = LAT_LOAD;
          state_next    = (LATENCY == 1) ? BURST : WAIT;
        end
      end

      WAIT: begin
        // The counter is loaded with LATENCY-1 at acceptance; leaving when it
        // steps from 1 to 0 lands the first beat LATENCY cycles after
        // acceptance because resp is registered off state_next.
        if (lat_cnt_reg <= LAT_ONE) begin
          lat_cnt_next = '0;
          state_next   = BURST;
        end else begin
          lat_cnt_next = lat_cnt_reg - LAT_ONE;
        end
      end

      BURST: begin
        if (beat_reg == LAST_BEAT) begin
          beat_next  = '0;
          state_next = DONE;
        end else begin
          beat_next = beat_reg + BEAT_ONE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (proto_violation) begin
      err_next = 1'b1;
    end
  end

  // ------------------------------------------------------------------------
  // Storage access. A write beat lands at the end of the cycle in which its
  // resp is high. Otherwise the port looks ahead at the word the next cycle
  // will present, so the registered rdata lines up with the registered resp.
  // A write burst never runs straight into a read burst (DONE sits between),
  // so one port serves both.
  // ------------------------------------------------------------------------
  assign write_beat = (state_reg == BURST) && op_write_reg;
  assign mem_we     = write_beat && reset_n;
  assign mem_addr   = write_beat ? {line_reg, beat_reg} : {line_next, beat_next};

  assign resp_next  = (state_next == BURST);
  assign rdata_next = (resp_next && !op_write_next) ? mem_rdata : '0;

  pmem_line_store #(
    .ADDR_W (WORD_W)
  ) u_line_store (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (bus.pmem_wdata),
    .rdata (mem_rdata)
  );

  // ------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      op_write_reg <= 1'b0;
      line_reg     <= '0;
      lat_cnt_reg  <= '0;
      beat_reg     <= '0;
      err_reg      <= 1'b0;
      resp_reg     <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      op_write_reg <= op_write_next;
      line_reg     <= line_next;
      lat_cnt_reg  <= lat_cnt_next;
      beat_reg     <= beat_next;
      err_reg      <= err_next;
      resp_reg     <= resp_next;
      rdata_reg    <= rdata_next;
    end
  end

  assign bus.pmem_resp  = resp_reg;
  assign bus.pmem_rdata = rdata_reg;
  assign bus.pmem_err   = err_reg;

endmodule

// File: tb/tb_pmem_burst_responder.sv
// ---------------------------------------------------------------------------
// tb_pmem_burst_responder
//
// Directed bench: the stimulus side pushes expected beats (data and the cycle
// they must appear in) into a queue; a negedge monitor pops and compares on
// every pmem_resp, and also checks the idle-beat and error-flag outputs.
// Two extra instances with LATENCY=1 and LATENCY=20 exercise beat timing
// across back-to-back bursts.
// ---------------------------------------------------------------------------
module tb_pmem_burst_responder;
  import pmem_pkg::*;

  localparam int MAIN_LAT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  pmem_burst_responder_if ifc ();

  pmem_burst_responder #(
    .s_offset (5),
    .s_lines  (10),
    .LATENCY  (MAIN_LAT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  // ------------------------------------------------------------------------
  // Scoreboard for the main instance
  // ------------------------------------------------------------------------
  typedef struct {
    logic [63:0] data;
    bit          chk;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  bit   mon_en  = 1'b0;
  logic exp_err = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if (ifc.pmem_err !== exp_err) begin
        bad++;
        $display("FAIL err_flag cyc=%0d got=%0b want=%0b", cyc, ifc.pmem_err, exp_err);
      end
      total++;
      if (ifc.pmem_resp) begin
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_resp cyc=%0d rdata=%h", cyc, ifc.pmem_rdata);
        end else begin
          e = q.pop_front();
          if (cyc != e.cyc || (e.chk && ifc.pmem_rdata !== e.data)) begin
            bad++;
            $display("FAIL beat cyc=%0d want_cyc=%0d got=%h want=%h",
                     cyc, e.cyc, ifc.pmem_rdata, e.chk ? e.data : ifc.pmem_rdata);
          end
        end
      end else if (ifc.pmem_rdata !== 64'd0) begin
        bad++;
        $display("FAIL rdata_idle cyc=%0d got=%h want=0", cyc, ifc.pmem_rdata);
      end
    end
  end

  // ------------------------------------------------------------------------
  // Latency probes
  // ------------------------------------------------------------------------
  logic lat_read [2];
  int   lat_seen [2];
  int   lat_exp  [2][8];

  initial begin
    lat_read[0] = 1'b0;
    lat_read[1] = 1'b0;
    lat_seen[0] = 0;
    lat_seen[1] = 0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lat
      localparam int LAT = (gi == 0) ? 1 : 20;
      pmem_burst_responder_if lifc ();

      assign lifc.pmem_read    = lat_read[gi];
      assign lifc.pmem_write   = 1'b0;
      assign lifc.pmem_address = 32'd0;
      assign lifc.pmem_wdata   = 64'd0;

      pmem_burst_responder #(
        .s_offset (5),
        .s_lines  (10),
        .LATENCY  (LAT)
      ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (lifc)
      );

      always @(negedge clk) begin
        if (lifc.pmem_resp) begin
          total++;
          if (lat_seen[gi] >= 8 || cyc != lat_exp[gi][lat_seen[gi]]) begin
            bad++;
            $display("FAIL lat%0d_beat idx=%0d cyc=%0d want_cyc=%0d", LAT, lat_seen[gi],
                     cyc, (lat_seen[gi] < 8) ? lat_exp[gi][lat_seen[gi]] : -1);
          end
          lat_seen[gi]++;
        end
      end
    end
  endgenerate

  // ------------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------------
  task automatic do_reset();
    @(negedge clk);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    exp_err = 1'b0;
    mon_en  = 1'b1;
  endtask

  // One line transaction on the main instance. rst_at>0 pulls reset in the
  // cycle of that beat count; use_bad moves the address during WAIT.
  task automatic do_txn(input bit wr, input logic [31:0] addr,
                        input logic [3:0][63:0] d, input int rst_at,
                        input logic [31:0] bad_addr, input bit use_bad);
    int c0, seen, nb;
    bit done;
    @(negedge clk);
    c0 = cyc;
    nb = (rst_at > 0) ? rst_at : 4;
    for (int b = 0; b < nb; b++) q.push_back('{d[b], !wr, c0 + MAIN_LAT + b});
    ifc.pmem_read    = !wr;
    ifc.pmem_write   = wr;
    ifc.pmem_address = addr;
    ifc.pmem_wdata   = d[0];
    seen = 0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (use_bad && cyc == c0 + 2) begin
        ifc.pmem_address = bad_addr;
        @(posedge clk);
        exp_err = 1'b1;
        continue;
      end
      if (ifc.pmem_resp) begin
        ifc.pmem_wdata = d[seen];
        seen++;
        if (seen == rst_at) begin
          reset_n        = 1'b0;
          ifc.pmem_read  = 1'b0;
          ifc.pmem_write = 1'b0;
          @(negedge clk);
          reset_n = 1'b1;
          done    = 1'b1;
        end else if (seen == 4) begin
          @(negedge clk);
          ifc.pmem_read  = 1'b0;
          ifc.pmem_write = 1'b0;
          done = 1'b1;
        end
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL txn_timeout addr=%h beats=%0d want=%0d", addr, seen, nb);
      ifc.pmem_read  = 1'b0;
      ifc.pmem_write = 1'b0;
    end
    $display("txn %s addr=%h beats=%0d", wr ? "write" : "read", addr, seen);
  endtask

  task automatic check_q_empty(input string name);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s pending=%0d want=0", name, q.size());
      q.delete();
    end
  endtask

  // ------------------------------------------------------------------------
  // Main sequence
  // ------------------------------------------------------------------------
  logic [3:0][63:0] d1, d2, dold, dnew, dmix;

  initial begin
    reset_n          = 1'b0;
    ifc.pmem_read    = 1'b0;
    ifc.pmem_write   = 1'b0;
    ifc.pmem_address = 32'd0;
    ifc.pmem_wdata   = 64'd0;

    d1[0] = 64'h1111_1111_1111_1111;
    d1[1] = 64'h2222_2222_2222_2222;
    d1[2] = 64'h3333_3333_3333_3333;
    d1[3] = 64'h4444_4444_4444_4444;
    for (int b = 0; b < 4; b++) begin
      d2[b]   = 64'h0123_4567_89AB_CD00 + 64'(b);
      dold[b] = 64'hA0A0_0000_0000_0000 + 64'(b);
      dnew[b] = 64'h5B5B_0000_0000_0000 + 64'(b);
    end
    dmix[0] = dnew[0];
    dmix[1] = dnew[1];
    dmix[2] = dold[2];
    dmix[3] = dold[3];

    // Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (20) @(negedge clk);
    $display("txn idle cycles=20");

    // Write / read the same line
    do_txn(1'b1, 32'h0000_1040, d1, 0, 32'd0, 1'b0);
    do_txn(1'b0, 32'h0000_1040, d1, 0, 32'd0, 1'b0);
    check_q_empty("write_read_line");

    // Aliasing and ignored offset bits
    do_txn(1'b1, 32'h0000_0020, d2, 0, 32'd0, 1'b0);
    do_txn(1'b0, 32'h0000_803C, d2, 0, 32'd0, 1'b0);
    check_q_empty("alias_offset");

    // Address moved during WAIT: flagged, burst stays on the original line
    do_txn(1'b0, 32'h0000_1040, d1, 0, 32'h0000_2040, 1'b1);
    check_q_empty("addr_change");
    do_reset();

    // Read and write together in IDLE: flagged, no transaction
    @(negedge clk);
    ifc.pmem_address = 32'h0000_1040;
    ifc.pmem_read    = 1'b1;
    ifc.pmem_write   = 1'b1;
    @(posedge clk);
    exp_err = 1'b1;
    @(negedge clk);
    ifc.pmem_read  = 1'b0;
    ifc.pmem_write = 1'b0;
    repeat (14) @(negedge clk);
    $display("txn both_requests err=%0b", ifc.pmem_err);
    check_q_empty("both_requests");
    do_reset();

    // Reset in the middle of a write burst to line 0x40
    do_txn(1'b1, 32'h0000_0800, dold, 0, 32'd0, 1'b0);
    do_txn(1'b1, 32'h0000_0800, dnew, 3, 32'd0, 1'b0);
    do_txn(1'b0, 32'h0000_0800, dmix, 0, 32'd0, 1'b0);
    check_q_empty("reset_mid_burst");

    // Latency sweep: two back-to-back reads per probe instance
    for (int p = 0; p < 2; p++) begin
      int lat, c0;
      bit got;
      lat = (p == 0) ? 1 : 20;
      @(negedge clk);
      c0 = cyc;
      for (int k = 0; k < 8; k++)
        lat_exp[p][k] = (k < 4) ? (c0 + lat + k) : (c0 + 2 * lat + 5 + (k - 4));
      lat_read[p] = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
        @(posedge clk);
        if (lat_seen[p] >= 8) got = 1'b1;
      end
      @(negedge clk);
      lat_read[p] = 1'b0;
      repeat (30) @(negedge clk);
      total++;
      if (lat_seen[p] != 8) begin
        bad++;
        $display("FAIL lat%0d_count got=%0d want=8", lat, lat_seen[p]);
      end
      $display("txn latency=%0d beats=%0d", lat, lat_seen[p]);
    end

    @(negedge clk);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
